// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, programmable almost
// thresholds, an occupancy count and a selectable first-word-fall-through read.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0,
  parameter int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Handshake: a write is taken when wr_en && !full, a read when rd_en && !empty;
  // wr_ack/overflow/underflow report the outcome of the previous cycle's request.
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = !full && (count >= CW'(AF_THRESH));
  assign almostempty = !empty && (count <= CW'(AE_THRESH));
  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) wr_ptr <= ptr_next(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_next(rd_ptr);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO. It succeeds the fixed 16x8 FIFO under test in the verification environment.
- Adds the following over that FIFO:
  - arbitrary (non-power-of-two) depth
  - programmable almost-full and almost-empty thresholds
  - an occupancy count output
  - a selectable first-word-fall-through (FWFT) read mode
- Sits between a single producer and a single consumer in one clock domain.
- Is driven directly by the randomized transaction bench.

Parameters:
- DATA_WIDTH, 16, width of data_in/data_out.
- DEPTH, 8, number of entries; any integer >= 2.
- AF_THRESH, DEPTH-1, almostfull asserts when count >= AF_THRESH and not full; legal range 1..DEPTH-1.
- AE_THRESH, 1, almostempty asserts when count <= AE_THRESH and not empty; legal range 1..DEPTH-1.
- FWFT, 0, read mode: 0 = registered read with 1-cycle latency; 1 = first-word-fall-through.
- CW, $clog2(DEPTH+1), width of count (derived; not overridden).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- wr_ack  out  1  registered; the previous cycle's write was accepted.
- overflow  out  1  registered; the previous cycle's write was rejected because the FIFO was full.
- underflow  out  1  registered; the previous cycle's read was rejected because the FIFO was empty.
- full  out  1  combinational: count == DEPTH.
- empty  out  1  combinational: count == 0.
- almostfull  out  1  combinational, per AF_THRESH.
- almostempty  out  1  combinational, per AE_THRESH.
- count  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0.
  - data_out, wr_ack, overflow and underflow go to 0.
  - Hence empty=1, full=0, almostfull=0, almostempty=0.
  - Memory contents are not cleared; any entries present are discarded.
  - Reset asserted mid-burst aborts the burst with no further ack.
- Write acceptance:
  - A write is accepted when wr_en=1 and full=0.
  - The entry is written at wr_ptr, wr_ptr advances, and wr_ack=1 on the next cycle.
  - wr_en=1 with full=1 is rejected: memory and wr_ptr are unchanged, overflow=1 on the next cycle.
- Read acceptance:
  - A read is accepted when rd_en=1 and empty=0, and rd_ptr advances.
  - rd_en=1 with empty=1 is rejected: underflow=1 on the next cycle, and data_out holds in FWFT=0.
- wr_ack, overflow and underflow are single-cycle status bits. Each is recomputed every cycle; none is sticky.
- Simultaneous write and read:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: the read is accepted, the write is rejected (overflow=1), and count becomes DEPTH-1.
  - Empty: the write is accepted, the read is rejected (underflow=1), and count becomes 1.
- count: +1 on an accepted write only, -1 on an accepted read only, unchanged otherwise.
- Pointer wrap: a pointer at DEPTH-1 wraps to 0. This applies to non-power-of-two DEPTH as well.
- FWFT=0:
  - On an accepted read, data_out is loaded with mem[rd_ptr] at that clock edge, so data is visible 1 cycle after the rd_en cycle.
  - data_out holds its value otherwise.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally while empty=0, and 0 while empty=1.
  - rd_en pops the displayed word.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- Status outputs are derived only from count. No flag glitches on a simultaneous write and read at steady occupancy.

Test Plan:
1. Reset, then 8 writes of 0x1000..0x1007 (DEPTH=8):
   - wr_ack=1 for each.
   - count steps 1..8; almostfull=1 at count=7; full=1 at count=8.
   - A 9th write gives overflow=1, and count stays 8.
2. Drain the full FIFO with 8 reads (FWFT=0):
   - data_out = 0x1000..0x1007, each appearing 1 cycle after its rd_en.
   - almostempty=1 at count=1; empty=1 at count=0.
   - A 9th read gives underflow=1, and data_out holds 0x1007.
3. Wrap test with DEPTH=5:
   - 3 writes, 3 reads, then 5 writes of 0xA0..0xA4 and 5 reads.
   - Read order is 0xA0..0xA4 with no loss; count ends at 0.
4. Simultaneous write and read:
   - At full: overflow=1, one word read, count=7.
   - At empty: underflow=1, wr_ack=1, count=1.
   - At count=4: count stays 4 and wr_ack=1.
5. FWFT=1:
   - Write 0x55AA into an empty FIFO; data_out=0x55AA on the next cycle with no rd_en.
   - rd_en pops it; data_out=0 once empty.
6. rst_n pulsed low for one negedge with count=5:
   - Immediately count=0, empty=1, and all status outputs are 0.
   - A subsequent write/read returns the new data, not stale entries.
